// File: rtl/varint_out_arbiter_if.sv
// Bundle between the varint arbiter, its per-lane output FIFOs and the downstream consumer.
// The master side belongs to the arbiter; the slave side is the FIFOs plus the consumer.
interface varint_out_arbiter_if #(
    parameter int unsigned N_SRC  = 4,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned SRC_W  = 2
) ();

    logic [N_SRC-1:0]        fifo_empty;
    logic [N_SRC*DATA_W-1:0] fifo_data;
    logic [N_SRC-1:0]        fifo_pop;
    logic [DATA_W-1:0]       varint_data;
    logic [SRC_W-1:0]        varint_src;
    logic                    varint_data_valid;
    logic                    varint_data_accepted;

    modport master (
        input  fifo_empty,
        input  fifo_data,
        input  varint_data_accepted,
        output fifo_pop,
        output varint_data,
        output varint_src,
        output varint_data_valid
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        output varint_data_accepted,
        input  fifo_pop,
        input  varint_data,
        input  varint_src,
        input  varint_data_valid
    );

endinterface

// File: rtl/varint_out_arbiter.sv
// Round-robin arbiter sharing one varint consumer between N_SRC lane FIFOs, with a per-grant
// burst limit. Each fetched word is held under a valid/accepted handshake.
module varint_out_arbiter #(
    parameter int unsigned N_SRC     = 4,
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned SRC_W     = 2,
    parameter int unsigned MAX_BURST = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   arb_enable,
    input  logic [N_SRC-1:0]       src_enable,
    varint_out_arbiter_if.master   bus
);

    localparam int unsigned CNT_W = 4;
    localparam logic [0:0] StArb   = 1'b0;
    localparam logic [0:0] StReady = 1'b1;
    localparam logic [CNT_W-1:0] MaxBurst = CNT_W'(MAX_BURST);

    logic [0:0]        state_q, state_d;
    logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [SRC_W-1:0]  grant_q, grant_d;
    logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
    logic [N_SRC-1:0]  pop_q, pop_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [SRC_W-1:0]  src_q, src_d;
    logic              valid_q, valid_d;

    logic [N_SRC-1:0]  eligible;
    logic              keep_grant;
    logic              rr_found;
    logic [SRC_W-1:0]  rr_pick;
    logic [SRC_W-1:0]  rr_idx;
    logic [SRC_W-1:0]  sel;
    logic [DATA_W-1:0] sel_data;

    function automatic logic [SRC_W-1:0] wrap_inc(input logic [SRC_W-1:0] v);
        return (v == SRC_W'(N_SRC - 1)) ? '0 : v + SRC_W'(1);
    endfunction

    assign eligible   = ~bus.fifo_empty & src_enable;
    assign keep_grant = eligible[grant_q] && (burst_cnt_q < MaxBurst) && (burst_cnt_q != '0);

    // First eligible source at or above rr_ptr, wrapping; the index walks so it never
    // produces a code >= N_SRC.
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = '0;
        rr_idx   = rr_ptr_q;
        for (int unsigned k = 0; k < N_SRC; k++) begin
            if (!rr_found && eligible[rr_idx]) begin
                rr_found = 1'b1;
                rr_pick  = rr_idx;
            end
            rr_idx = wrap_inc(rr_idx);
        end
    end

    assign sel = keep_grant ? grant_q : rr_pick;

    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (sel == SRC_W'(i)) begin
                sel_data = bus.fifo_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        burst_cnt_d = burst_cnt_q;
        pop_d       = '0;
        data_d      = data_q;
        src_d       = src_q;
        valid_d     = valid_q;
        unique case (state_q)
            StArb: begin
                // rr_found is equivalent to any source being eligible.
                if (arb_enable && rr_found) begin
                    if (keep_grant) begin
                        burst_cnt_d = burst_cnt_q + CNT_W'(1);
                    end else begin
                        burst_cnt_d = CNT_W'(1);
                        rr_ptr_d    = wrap_inc(rr_pick);
                    end
                    data_d  = sel_data;
                    src_d   = sel;
                    valid_d = 1'b1;
                    pop_d   = N_SRC'(1) << sel;
                    grant_d = sel;
                    state_d = StReady;
                end
            end
            StReady: begin
                if (bus.varint_data_accepted) begin
                    valid_d = 1'b0;
                    state_d = StArb;
                end
            end
            default: state_d = StArb;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StArb;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            burst_cnt_q <= '0;
            pop_q       <= '0;
            data_q      <= '0;
            src_q       <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            burst_cnt_q <= burst_cnt_d;
            pop_q       <= pop_d;
            data_q      <= data_d;
            src_q       <= src_d;
            valid_q     <= valid_d;
        end
    end

    assign bus.fifo_pop          = pop_q;
    assign bus.varint_data       = data_q;
    assign bus.varint_src        = src_q;
    assign bus.varint_data_valid = valid_q;

    pop_onehot_a: assert property (@(posedge clk) disable iff (!reset) $onehot0(pop_q));

    hold_stable_a: assert property (@(posedge clk) disable iff (!reset)
        valid_q && !bus.varint_data_accepted |=> valid_q && $stable(data_q) && $stable(src_q));

endmodule

// File: tb/tb_varint_out_arbiter.sv
// Directed bench for varint_out_arbiter: three instances (MAX_BURST 2, 1, 4), each fed by
// simple array FIFO models, with hand-computed word orders, pop counts and timing.
module tb_varint_out_arbiter;

    localparam int unsigned NS = 4;
    localparam int unsigned DW = 64;
    localparam int unsigned SW = 2;
    localparam int unsigned ND = 3;
    localparam int unsigned QD = 16;
    localparam int unsigned LD = 64;

    logic clk = 1'b0;
    logic reset;
    logic            arb_en [ND];
    logic [NS-1:0]   src_en [ND];
    logic            acc    [ND];

    logic [DW-1:0]   mem  [ND][NS][QD];
    logic [4:0]      head [ND][NS];
    logic [4:0]      tail [ND][NS];

    logic [DW-1:0]   o_data  [ND];
    logic [SW-1:0]   o_src   [ND];
    logic            o_valid [ND];
    logic [NS-1:0]   o_pop   [ND];

    int pops     [ND][NS] = '{default: 0};
    int bad_pops [ND]     = '{default: 0};
    int log_n    [ND]     = '{default: 0};
    logic [DW-1:0] log_data [ND][LD];
    logic [SW-1:0] log_src  [ND][LD];
    int            log_t    [ND][LD];
    int cyc = 0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    for (genvar d = 0; d < ND; d++) begin : g_dut
        varint_out_arbiter_if #(.N_SRC(NS), .DATA_W(DW), .SRC_W(SW)) bus ();
        for (genvar i = 0; i < NS; i++) begin : g_src
            assign bus.fifo_empty[i]         = (head[d][i] == tail[d][i]);
            assign bus.fifo_data[i*DW +: DW] = mem[d][i][head[d][i][3:0]];
        end
        assign bus.varint_data_accepted = acc[d];
        assign o_data[d]  = bus.varint_data;
        assign o_src[d]   = bus.varint_src;
        assign o_valid[d] = bus.varint_data_valid;
        assign o_pop[d]   = bus.fifo_pop;

        varint_out_arbiter #(
            .N_SRC    (NS),
            .DATA_W   (DW),
            .SRC_W    (SW),
            .MAX_BURST(d == 0 ? 2 : (d == 1 ? 1 : 4))
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .arb_enable(arb_en[d]),
            .src_enable(src_en[d]),
            .bus       (bus)
        );
    end

    // FIFO models, pop bookkeeping and accepted-word log.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int d = 0; d < ND; d++)
                for (int i = 0; i < NS; i++) head[d][i] <= '0;
        end else begin
            cyc <= cyc + 1;
            for (int d = 0; d < ND; d++) begin
                if ((o_pop[d] & (o_pop[d] - 1'b1)) != '0) bad_pops[d] <= bad_pops[d] + 1;
                for (int i = 0; i < NS; i++) begin
                    if (o_pop[d][i]) begin
                        if (head[d][i] == tail[d][i]) bad_pops[d] <= bad_pops[d] + 1;
                        head[d][i] <= head[d][i] + 5'd1;
                        pops[d][i] <= pops[d][i] + 1;
                    end
                end
                if (o_valid[d] && acc[d] && log_n[d] < LD) begin
                    log_data[d][log_n[d]] <= o_data[d];
                    log_src[d][log_n[d]]  <= o_src[d];
                    log_t[d][log_n[d]]    <= cyc;
                    log_n[d]              <= log_n[d] + 1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int d, input int s, input logic [DW-1:0] w);
        mem[d][s][tail[d][s][3:0]] = w;
        tail[d][s] = tail[d][s] + 5'd1;
    endtask

    int base, bad, p0;
    logic [SW-1:0] exp_src5 [9];
    logic [DW-1:0] exp_dat5 [9];

    initial begin
        exp_src5 = '{2'd0, 2'd1, 2'd1, 2'd3, 2'd3, 2'd0, 2'd0, 2'd1, 2'd3};
        exp_dat5 = '{64'h00, 64'h10, 64'h11, 64'h30, 64'h31, 64'h01, 64'h02, 64'h12, 64'h32};
        reset = 1'b0;
        for (int d = 0; d < ND; d++) begin
            arb_en[d] = 1'b1;
            src_en[d] = '1;
            acc[d]    = 1'b0;
            for (int i = 0; i < NS; i++) tail[d][i] = '0;
        end

        // Reset and idle.
        tick(2);
        check("rst_valid", 64'(o_valid[0]), 64'd0);
        check("rst_pop", 64'(o_pop[0]), 64'd0);
        check("rst_data", o_data[0], 64'd0);
        check("rst_src", 64'(o_src[0]), 64'd0);
        reset = 1'b1;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            if (o_valid[0] || o_pop[0] != '0) bad++;
        end
        check("idle_quiet", 64'(bad), 64'd0);

        // Single source held under stall.
        push(0, 2, 64'hA5);
        tick(1);
        check("t2_valid", 64'(o_valid[0]), 64'd1);
        check("t2_pop", 64'(o_pop[0]), 64'b0100);
        check("t2_data", o_data[0], 64'hA5);
        check("t2_src", 64'(o_src[0]), 64'd2);
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            tick(1);
            if (!o_valid[0] || o_data[0] != 64'hA5 || o_src[0] != 2'd2 || o_pop[0] != '0) bad++;
        end
        check("t2_hold", 64'(bad), 64'd0);
        acc[0] = 1'b1;
        tick(1);
        acc[0] = 1'b0;
        check("t2_valid_fall", 64'(o_valid[0]), 64'd0);
        check("t2_data_kept", o_data[0], 64'hA5);
        check("t2_pop_cnt", 64'(pops[0][2]), 64'd1);

        // Asynchronous reset while a word is presented.
        push(0, 1, 64'h77);
        tick(1);
        check("rst_mid_pre", 64'(o_valid[0]), 64'd1);
        #2 reset = 1'b0;
        #1;
        check("rst_mid_valid", 64'(o_valid[0]), 64'd0);
        check("rst_mid_pop", 64'(o_pop[0]), 64'd0);
        for (int d = 0; d < ND; d++)
            for (int i = 0; i < NS; i++) tail[d][i] = '0;
        tick(1);
        reset = 1'b1;
        tick(2);
        check("rst_mid_idle", 64'(o_valid[0]), 64'd0);

        // Burst limit 2: expect 1, 2, 10, 3 one word every 2 cycles.
        base = log_n[0];
        push(0, 0, 64'd1); push(0, 0, 64'd2); push(0, 0, 64'd3); push(0, 1, 64'd10);
        acc[0] = 1'b1;
        tick(12);
        acc[0] = 1'b0;
        check("t3_count", 64'(log_n[0] - base), 64'd4);
        check("t3_d0", log_data[0][base],   64'd1);
        check("t3_d1", log_data[0][base+1], 64'd2);
        check("t3_d2", log_data[0][base+2], 64'd10);
        check("t3_d3", log_data[0][base+3], 64'd3);
        check("t3_s0", 64'(log_src[0][base]),   64'd0);
        check("t3_s1", 64'(log_src[0][base+1]), 64'd0);
        check("t3_s2", 64'(log_src[0][base+2]), 64'd1);
        check("t3_s3", 64'(log_src[0][base+3]), 64'd0);
        for (int j = 1; j < 4; j++)
            check("t3_gap", 64'(log_t[0][base+j] - log_t[0][base+j-1]), 64'd2);

        // Masking: source 2 disabled with every FIFO holding three words.
        base = log_n[0];
        p0   = pops[0][2];
        src_en[0] = 4'b1011;
        for (int s = 0; s < NS; s++)
            for (int k = 0; k < 3; k++) push(0, s, 64'(s * 16 + k));
        acc[0] = 1'b1;
        tick(24);
        acc[0] = 1'b0;
        check("t5_count", 64'(log_n[0] - base), 64'd9);
        for (int j = 0; j < 9; j++) begin
            check("t5_src", 64'(log_src[0][base+j]), 64'(exp_src5[j]));
            check("t5_data", log_data[0][base+j], exp_dat5[j]);
        end
        check("t5_no_pop2", 64'(pops[0][2] - p0), 64'd0);

        // arb_enable dropped during READY: word completes, then nothing until re-enabled.
        src_en[0] = 4'b1111;
        tick(1);
        check("t5b_valid", 64'(o_valid[0]), 64'd1);
        check("t5b_src", 64'(o_src[0]), 64'd2);
        check("t5b_data", o_data[0], 64'h20);
        arb_en[0] = 1'b0;
        acc[0] = 1'b1;
        tick(1);
        check("t5b_done", 64'(o_valid[0]), 64'd0);
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            tick(1);
            if (o_valid[0] || o_pop[0] != '0) bad++;
        end
        check("t5b_paused", 64'(bad), 64'd0);
        check("t5b_pop2", 64'(pops[0][2] - p0), 64'd1);
        acc[0] = 1'b0;
        arb_en[0] = 1'b1;
        tick(1);
        check("t5b_resume_v", 64'(o_valid[0]), 64'd1);
        check("t5b_resume_d", o_data[0], 64'h21);
        acc[0] = 1'b1;
        tick(6);
        acc[0] = 1'b0;

        // Pure round robin on the MAX_BURST=1 instance.
        base = log_n[1];
        for (int s = 0; s < NS; s++)
            for (int k = 0; k < 4; k++) push(1, s, 64'(s * 16 + k));
        acc[1] = 1'b1;
        tick(40);
        acc[1] = 1'b0;
        check("t4_count", 64'(log_n[1] - base), 64'd16);
        for (int j = 0; j < 16; j++) begin
            check("t4_src", 64'(log_src[1][base+j]), 64'(j % 4));
            check("t4_data", log_data[1][base+j], 64'((j % 4) * 16 + j / 4));
        end
        for (int i = 0; i < NS; i++) check("t4_pops", 64'(pops[1][i]), 64'd4);

        // Early empty on the MAX_BURST=4 instance.
        base = log_n[2];
        acc[2] = 1'b1;
        push(2, 3, 64'h30);
        tick(1);
        for (int k = 0; k < 5; k++) push(2, 0, 64'(k));
        tick(16);
        acc[2] = 1'b0;
        check("t6_count", 64'(log_n[2] - base), 64'd6);
        check("t6_first_src", 64'(log_src[2][base]), 64'd3);
        check("t6_first_data", log_data[2][base], 64'h30);
        for (int j = 1; j < 6; j++) begin
            check("t6_src", 64'(log_src[2][base+j]), 64'd0);
            check("t6_data", log_data[2][base+j], 64'(j - 1));
            check("t6_gap", 64'(log_t[2][base+j] - log_t[2][base+j-1]), 64'd2);
        end

        for (int d = 0; d < ND; d++) check("pop_legal", 64'(bad_pops[d]), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/varint_out_arbiter.md
Name: varint_out_arbiter

Overview:
- Round-robin scheduler that shares one downstream varint consumer between N varint output FIFOs, one per decode lane.
- Pops one word from the granted FIFO and presents it with its source index.
- Holds the word under a valid/accepted handshake.
- Supports a per-grant burst limit so one busy lane cannot starve the others.

Parameters:
- N_SRC, 4, number of varint output FIFOs (2..8).
- DATA_W, 64, width of one decoded varint word.
- SRC_W, 2, width of source index; must satisfy 2**SRC_W >= N_SRC.
- MAX_BURST, 2, maximum consecutive words taken from one source before rotating (1..15).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  reset, asynchronous, active-low.
- arb_enable  input  1  when low, no new word is fetched; a word already presented still completes.
- src_enable  input  N_SRC  per-source mask; a source with its bit low is never granted.
- fifo_empty  input  N_SRC  per-FIFO empty flag, bit i for FIFO i.
- fifo_data  input  N_SRC*DATA_W  show-ahead head word; FIFO i occupies bits [i*DATA_W +: DATA_W].
- fifo_pop  output  N_SRC  registered one-hot pop pulse, one cycle wide.
- varint_data  output  DATA_W  presented word.
- varint_src  output  SRC_W  index of the FIFO that supplied varint_data.
- varint_data_valid  output  1  varint_data and varint_src are valid.
- varint_data_accepted  input  1  consumer takes the word on a clock edge where valid=1.

Behaviour:
- Reset (reset=0, async):
  - state=ARB; fifo_pop=0; varint_data=0; varint_src=0; varint_data_valid=0.
  - rr_ptr=0; grant=0; burst_cnt=0.
  - Reset asserted mid-word discards the word. The FIFO is not re-pushed; that word is lost by design.
- Eligible set:
  - eligible[i] = !fifo_empty[i] && src_enable[i].
  - Evaluated only in state ARB.
- State ARB, at each rising edge:
  - If arb_enable=0 or no eligible source: stay in ARB; fifo_pop=0.
  - Else select source g:
    - Keep grant (g=grant) if eligible[grant] && burst_cnt < MAX_BURST && burst_cnt != 0.
    - Otherwise g = first eligible index searching upward from rr_ptr with wrap.
    - On a new grant: burst_cnt <= 1 and rr_ptr <= (g+1) mod N_SRC.
    - On a kept grant: burst_cnt <= burst_cnt+1.
  - Register outputs:
    - varint_data <= fifo_data[g]; varint_src <= g; varint_data_valid <= 1.
    - fifo_pop <= onehot(g); grant <= g; go to READY.
- State READY:
  - fifo_pop <= 0 at the first edge.
  - varint_data and varint_src are held stable while valid=1 and accepted=0, for any number of cycles.
  - On an edge with varint_data_accepted=1: valid <= 0; go to ARB.
  - Data is not cleared on accept (holds last value).
- Timing and latency:
  - Pop is a single cycle: high during the first READY cycle only.
  - The FIFO registers the pop at the following edge, so fifo_empty is settled by the next ARB evaluation even with an immediate accept.
  - Latency: one cycle from an eligible source seen at an ARB edge to valid=1.
  - Peak throughput: one word per 2 cycles.
- Handshake and control corner cases:
  - varint_data_accepted while valid=0 is ignored.
  - arb_enable or src_enable changes during READY do not affect the presented word. They take effect at the next ARB edge.
  - If src_enable[grant] drops, the burst ends and rotation proceeds.
- Burst and rotation:
  - A burst ends early if the granted FIFO goes empty; the next ARB edge rotates to another source.
  - With one eligible source, it is re-granted after rotation with no idle cycle; burst_cnt restarts at 1.
  - MAX_BURST=1 gives pure round robin.
- Index widths:
  - All index arithmetic wraps modulo N_SRC.
  - Unused codes of SRC_W are never produced.
- Invariants:
  - fifo_pop is never asserted for an empty or disabled FIFO.
  - fifo_pop is at most one-hot.

Test Plan:
1. Reset and idle: reset=0 for 2 cycles, then reset=1 with all fifo_empty=4'b1111. Required: valid=0 and fifo_pop=0 for 10 cycles; reset mid-READY forces valid=0 asynchronously.
2. Single source with stall: FIFO2 holds 0xA5, accepted=0 for 5 cycles. Required: one fifo_pop=4'b0100 pulse; varint_data=0xA5 and src=2 held for all 5 cycles; valid falls on the edge after accepted=1.
3. Burst limit (MAX_BURST=2): FIFO0 holds {1,2,3}, FIFO1 holds {10}, accepted=1 tied high. Required: output order 1, 2, 10, 3 with srcs 0, 0, 1, 0; one word every 2 cycles.
4. Round-robin fairness: all four FIFOs hold 4 words each, MAX_BURST=1. Required: src sequence 0,1,2,3 repeated; each fifo_pop bit pulses exactly 4 times.
5. Masking and enable: src_enable=4'b1011 with all FIFOs non-empty. Required: src 2 never granted. Then arb_enable=0 during READY. Required: the current word completes and no further pop occurs until arb_enable=1.
6. Early empty: FIFO3 holds one word, MAX_BURST=4, FIFO0 holds 5 words. Required: after FIFO3's word, the next grant is src 0 with no stalled ARB cycle beyond the normal bubble.
